// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback arbiter's producer handshakes, issue-stage queries and
// register file write port; master is the surrounding pipeline, slave is the arbiter.
interface wb_arbiter_if;
    logic        exe_valid;
    logic        exe_ready;
    logic        exe_rd_en;
    logic [4:0]  exe_rd_idx;
    logic [31:0] exe_rd_data;

    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd_idx;
    logic [31:0] mem_rdata;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;

    logic        iss_valid;
    logic [4:0]  iss_rd_idx;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic        rs1_busy;
    logic        rs2_busy;

    logic        wb_rd_en;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_rd_data;

    modport master (
        output exe_valid, exe_rd_en, exe_rd_idx, exe_rd_data,
        output mem_valid, mem_rd_idx, mem_rdata, mem_funct3, mem_addr_lo,
        output iss_valid, iss_rd_idx, rs1_idx, rs2_idx,
        input  exe_ready, mem_ready, rs1_busy, rs2_busy,
        input  wb_rd_en, wb_rd_idx, wb_rd_data
    );

    modport slave (
        input  exe_valid, exe_rd_en, exe_rd_idx, exe_rd_data,
        input  mem_valid, mem_rd_idx, mem_rdata, mem_funct3, mem_addr_lo,
        input  iss_valid, iss_rd_idx, rs1_idx, rs2_idx,
        output exe_ready, mem_ready, rs1_busy, rs2_busy,
        output wb_rd_en, wb_rd_idx, wb_rd_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges execute and load results onto the register file write port,
// formats load data, and tracks pending destinations for issue-stage RAW stalls.
module wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    wb_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [3:0]  r_starve_cnt;
    logic [31:0] r_pend;
    logic        r_wb_rd_en;
    logic [4:0]  r_wb_rd_idx;
    logic [31:0] r_wb_rd_data;

    logic        w_force;
    logic        w_exe_ready;
    logic        w_mem_ready;
    logic        w_exe_xfer;
    logic        w_mem_xfer;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_sel_en;
    logic [4:0]  w_sel_idx;
    logic [31:0] w_sel_data;
    logic [31:0] w_pend_next;

    // Loads normally win; a starved execute result is forced through for one cycle.
    assign w_force     = bus.exe_valid && (r_starve_cnt == STARVE_LIMIT);
    assign w_exe_ready = w_force || !bus.mem_valid;
    assign w_mem_ready = !w_force;
    assign w_exe_xfer  = bus.exe_valid && w_exe_ready;
    assign w_mem_xfer  = bus.mem_valid && w_mem_ready;

    assign bus.exe_ready = w_exe_ready;
    assign bus.mem_ready = w_mem_ready;

    always_comb begin
        w_byte      = bus.mem_rdata[{bus.mem_addr_lo, 3'b000} +: 8];
        w_half      = bus.mem_rdata[{bus.mem_addr_lo[1], 4'b0000} +: 16];
        w_load_data = 32'd0;
        case (bus.mem_funct3)
            F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            F3_LW:   w_load_data = bus.mem_rdata;
            F3_LBU:  w_load_data = {24'd0, w_byte};
            F3_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_starve_cnt <= 4'd0;
        end else if (!bus.exe_valid || w_exe_xfer) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != STARVE_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Idle cycles keep the last index/data so only the enable pulses.
    always_comb begin
        w_sel_en   = 1'b0;
        w_sel_idx  = r_wb_rd_idx;
        w_sel_data = r_wb_rd_data;
        if (w_mem_xfer) begin
            w_sel_en   = 1'b1;
            w_sel_idx  = bus.mem_rd_idx;
            w_sel_data = w_load_data;
        end else if (w_exe_xfer) begin
            w_sel_en   = bus.exe_rd_en;
            w_sel_idx  = bus.exe_rd_idx;
            w_sel_data = bus.exe_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wb_rd_en   <= 1'b0;
            r_wb_rd_idx  <= 5'd0;
            r_wb_rd_data <= 32'd0;
        end else begin
            r_wb_rd_en   <= w_sel_en && (w_sel_idx != 5'd0);
            r_wb_rd_idx  <= w_sel_idx;
            r_wb_rd_data <= w_sel_data;
        end
    end

    assign bus.wb_rd_en   = r_wb_rd_en;
    assign bus.wb_rd_idx  = r_wb_rd_idx;
    assign bus.wb_rd_data = r_wb_rd_data;

    // A fresh issue to the register being retired must stay pending, so set follows clear.
    always_comb begin
        w_pend_next = r_pend;
        if (r_wb_rd_en) begin
            w_pend_next[r_wb_rd_idx] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd_idx != 5'd0)) begin
            w_pend_next[bus.iss_rd_idx] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pend <= 32'd0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign bus.rs1_busy = r_pend[bus.rs1_idx];
    assign bus.rs2_busy = r_pend[bus.rs2_idx];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, arbitration, starvation, load formatting,
// scoreboard and x0 handling, with hand-computed expectations.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad = 0;
    logic expForce;

    logic [2:0]  ldF3   [12];
    logic [1:0]  ldAddr [12];
    logic [31:0] ldExp  [12];

    wb_arbiter_if bus();

    wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic exeValid, input logic exeEn, input logic [4:0] exeIdx,
                                 input logic [31:0] exeData, input logic memValid, input logic [4:0] memIdx,
                                 input logic [31:0] memData, input logic [2:0] funct3, input logic [1:0] addrLo,
                                 input logic issValid, input logic [4:0] issIdx);
        bus.exe_valid   = exeValid;
        bus.exe_rd_en   = exeEn;
        bus.exe_rd_idx  = exeIdx;
        bus.exe_rd_data = exeData;
        bus.mem_valid   = memValid;
        bus.mem_rd_idx  = memIdx;
        bus.mem_rdata   = memData;
        bus.mem_funct3  = funct3;
        bus.mem_addr_lo = addrLo;
        bus.iss_valid   = issValid;
        bus.iss_rd_idx  = issIdx;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        ldF3   = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010,
                   3'b000, 3'b100, 3'b001, 3'b101, 3'b011, 3'b110};
        ldAddr = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0,
                   2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
        ldExp  = '{32'hFFFFFF81, 32'h00000081, 32'h0000007F, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F81,
                   32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h00007F81, 32'h00000000, 32'h00000000};

        // Reset held for two cycles with traffic on every port
        rstn = 1'b0;
        bus.rs1_idx = 5'd0;
        bus.rs2_idx = 5'd0;
        applyStimulus(1'b1, 1'b1, 5'd9, 32'hCAFE0009, 1'b1, 5'd10, 32'h12345678, 3'b010, 2'd0, 1'b1, 5'd12);
        tick();
        tick();
        checkOutput("rst_wb_en", bus.wb_rd_en, 32'd0);
        checkOutput("rst_wb_idx", bus.wb_rd_idx, 32'd0);
        checkOutput("rst_wb_data", bus.wb_rd_data, 32'd0);
        for (int i = 0; i < 32; i++) begin
            bus.rs1_idx = 5'(i);
            bus.rs2_idx = 5'(31 - i);
            #1;
            checkOutput($sformatf("rst_rs1_busy[%0d]", i), bus.rs1_busy, 32'd0);
            checkOutput($sformatf("rst_rs2_busy[%0d]", 31 - i), bus.rs2_busy, 32'd0);
        end
        idle();
        rstn = 1'b1;
        tick();
        checkOutput("post_rst_wb_en", bus.wb_rd_en, 32'd0);

        // Execute only
        applyStimulus(1'b1, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0);
        checkOutput("exe_only_ready", bus.exe_ready, 32'd1);
        tick();
        idle();
        checkOutput("exe_only_wb_en", bus.wb_rd_en, 32'd1);
        checkOutput("exe_only_wb_idx", bus.wb_rd_idx, 32'd5);
        checkOutput("exe_only_wb_data", bus.wb_rd_data, 32'h12345678);
        tick();
        checkOutput("exe_only_wb_en_drop", bus.wb_rd_en, 32'd0);
        checkOutput("exe_only_wb_idx_hold", bus.wb_rd_idx, 32'd5);
        checkOutput("exe_only_wb_data_hold", bus.wb_rd_data, 32'h12345678);

        // Collision: mem first, exe the following cycle
        applyStimulus(1'b1, 1'b1, 5'd4, 32'hAAAA0004, 1'b1, 5'd3, 32'h11223344, 3'b010, 2'd0, 1'b0, 5'd0);
        checkOutput("coll_mem_ready", bus.mem_ready, 32'd1);
        checkOutput("coll_exe_ready", bus.exe_ready, 32'd0);
        tick();
        checkOutput("coll_wb1_en", bus.wb_rd_en, 32'd1);
        checkOutput("coll_wb1_idx", bus.wb_rd_idx, 32'd3);
        checkOutput("coll_wb1_data", bus.wb_rd_data, 32'h11223344);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'hAAAA0004, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0);
        checkOutput("coll_exe_ready2", bus.exe_ready, 32'd1);
        tick();
        idle();
        checkOutput("coll_wb2_en", bus.wb_rd_en, 32'd1);
        checkOutput("coll_wb2_idx", bus.wb_rd_idx, 32'd4);
        checkOutput("coll_wb2_data", bus.wb_rd_data, 32'hAAAA0004);
        tick();
        checkOutput("coll_wb3_en", bus.wb_rd_en, 32'd0);

        // Starvation: exe forced through every fifth cycle
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h00000888, 1'b1, 5'd6, 32'h00000666, 3'b010, 2'd0, 1'b0, 5'd0);
        for (int c = 0; c < 10; c++) begin
            expForce = ((c % 5) == 4);
            checkOutput($sformatf("starve_exe_ready[%0d]", c), bus.exe_ready, {31'd0, expForce});
            checkOutput($sformatf("starve_mem_ready[%0d]", c), bus.mem_ready, {31'd0, !expForce});
            tick();
            checkOutput($sformatf("starve_wb_idx[%0d]", c), bus.wb_rd_idx, expForce ? 32'd8 : 32'd6);
        end
        idle();
        tick();

        // Dropping exe_valid restarts the starvation count
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h00000888, 1'b1, 5'd6, 32'h00000666, 3'b010, 2'd0, 1'b0, 5'd0);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h00000666, 3'b010, 2'd0, 1'b0, 5'd0);
        checkOutput("restart_mem_ready", bus.mem_ready, 32'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h00000888, 1'b1, 5'd6, 32'h00000666, 3'b010, 2'd0, 1'b0, 5'd0);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("restart_exe_ready[%0d]", k), bus.exe_ready, (k == 4) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
        tick();

        // Load formatting on mem_rdata = 0x80FF7F81
        for (int v = 0; v < 12; v++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h80FF7F81, ldF3[v], ldAddr[v], 1'b0, 5'd0);
            tick();
            checkOutput($sformatf("load_en[%0d]", v), bus.wb_rd_en, 32'd1);
            checkOutput($sformatf("load_data[%0d]", v), bus.wb_rd_data, ldExp[v]);
        end
        idle();
        tick();

        // Scoreboard: issue rd=7, retire, re-issue in the clear cycle
        bus.rs1_idx = 5'd7;
        bus.rs2_idx = 5'd8;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 5'd7);
        checkOutput("sb_before_issue", bus.rs1_busy, 32'd0);
        tick();
        idle();
        checkOutput("sb_busy_after_issue", bus.rs1_busy, 32'd1);
        checkOutput("sb_other_not_busy", bus.rs2_busy, 32'd0);
        tick();
        checkOutput("sb_busy_held", bus.rs1_busy, 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0);
        tick();
        checkOutput("sb_wb7_en", bus.wb_rd_en, 32'd1);
        checkOutput("sb_wb7_idx", bus.wb_rd_idx, 32'd7);
        checkOutput("sb_no_bypass", bus.rs1_busy, 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 5'd7);
        tick();
        idle();
        checkOutput("sb_set_wins", bus.rs1_busy, 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h00000078, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0);
        tick();
        idle();
        checkOutput("sb_wb7b_en", bus.wb_rd_en, 32'd1);
        checkOutput("sb_busy_in_wb_cycle", bus.rs1_busy, 32'd1);
        tick();
        checkOutput("sb_cleared", bus.rs1_busy, 32'd0);

        // x0 never becomes busy and is never written
        bus.rs1_idx = 5'd0;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 5'd0);
        tick();
        idle();
        checkOutput("x0_not_busy", bus.rs1_busy, 32'd0);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hDEAD0000, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0);
        checkOutput("x0_exe_ready", bus.exe_ready, 32'd1);
        tick();
        idle();
        checkOutput("x0_wb_en", bus.wb_rd_en, 32'd0);

        // exe_rd_en=0 handshakes but neither writes nor clears pending state
        bus.rs1_idx = 5'd9;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 5'd9);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd9, 32'h99999999, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0);
        checkOutput("noen_exe_ready", bus.exe_ready, 32'd1);
        tick();
        idle();
        checkOutput("noen_wb_en", bus.wb_rd_en, 32'd0);
        tick();
        checkOutput("noen_still_busy", bus.rs1_busy, 32'd1);

        // Reset mid-transfer drops the result and clears pending state
        applyStimulus(1'b1, 1'b1, 5'd13, 32'h13131313, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0);
        rstn = 1'b0;
        tick();
        checkOutput("midrst_wb_en", bus.wb_rd_en, 32'd0);
        checkOutput("midrst_wb_idx", bus.wb_rd_idx, 32'd0);
        checkOutput("midrst_busy", bus.rs1_busy, 32'd0);
        idle();
        rstn = 1'b1;
        tick();
        checkOutput("midrst_after_en", bus.wb_rd_en, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback stage feeding the register file write port (wb_rd_en / wb_rd_idx / wb_rd_data). Accepts results from two producers, the ALU/execute path and the load path, over valid/ready handshakes, and arbitrates one write per cycle. Formats load data by size and sign. Keeps a pending-write scoreboard so issue can stall on RAW hazards against in-flight destinations.

Parameters:
STARVE_MAX, 4, consecutive cycles exe may be blocked by mem before exe is forced to win one cycle (range 1..15)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  synchronous active-low reset
exe_valid  input  1  execute result valid
exe_ready  output  1  execute result accepted this cycle
exe_rd_en  input  1  execute result writes a register
exe_rd_idx  input  5  execute destination
exe_rd_data  input  32  execute result
mem_valid  input  1  load result valid
mem_ready  output  1  load result accepted this cycle
mem_rd_idx  input  5  load destination
mem_rdata  input  32  raw aligned word from data memory
mem_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
mem_addr_lo  input  2  load byte address bits [1:0]
iss_valid  input  1  instruction issued with a destination
iss_rd_idx  input  5  issued destination index
rs1_idx  input  5  issue-stage source 1 query
rs2_idx  input  5  issue-stage source 2 query
rs1_busy  output  1  rs1_idx has a pending write
rs2_busy  output  1  rs2_idx has a pending write
wb_rd_en  output  1  register file write enable
wb_rd_idx  output  5  register file write index
wb_rd_data  output  32  register file write data

Behaviour:
- Reset (rstn=0 at posedge): wb_rd_en=0, wb_rd_idx=0, wb_rd_data=0, starve counter=0, pend[31:0]=0. Reset mid-transfer drops the in-flight result. Nothing is written after reset.
- Arbitration (combinational):
  - Default: mem has priority. mem_ready=1 and exe_ready=~mem_valid.
  - Force mode: when starve_cnt==STARVE_MAX, exe_ready=1 and mem_ready=0. Applies only while exe_valid=1; otherwise default rules hold.
- Starve counter: increments when exe_valid & ~exe_ready. Clears on any exe handshake or when exe_valid=0. Saturates at STARVE_MAX.
- Handshake: a transfer occurs when valid & ready. At most one transfer per cycle. Producers hold payload stable while valid & ~ready.
- Output register: the transfer at edge N appears on wb_* at edge N+1, for one cycle only.
  - wb_rd_en = rd_en & (rd_idx != 0). mem rd_en is always 1.
  - With no transfer, wb_rd_en=0 and wb_rd_idx/wb_rd_data hold their old values.
- Load formatting:
  - Byte: select mem_rdata[8*addr_lo +: 8]. Half: select [16*addr_lo[1] +: 16], with addr_lo[0] ignored.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Other funct3 values produce 0.
- Scoreboard:
  - Set pend[iss_rd_idx] on iss_valid when iss_rd_idx != 0.
  - Clear pend[wb_rd_idx] in the cycle wb_rd_en=1.
  - Same index set and cleared in the same cycle: set wins.
  - pend[0] is always 0.
  - rs1_busy=pend[rs1_idx], rs2_busy=pend[rs2_idx], combinational from the registered pend. No bypass of the same-cycle clear.
  - Issue never issues to an already-pending rd (WAW stall is the issue stage's duty). This block does not check it.
- An exe result with exe_rd_en=0 still handshakes and still consumes the write slot.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with traffic on both ports -> wb_rd_en=0, wb_rd_idx=0, wb_rd_data=0, rs1_busy=rs2_busy=0 on every idx.
- exe only: exe_valid, rd_idx=5, data=0x1234_5678 -> exe_ready=1 same cycle; next cycle wb_rd_en=1, idx=5, data=0x12345678; the cycle after, wb_rd_en=0.
- Collision: both ports valid, mem idx=3, exe idx=4 -> mem written first; exe written the following cycle; exactly one wb_rd_en pulse per cycle.
- Starvation: mem_valid held high for 10 cycles, exe_valid high, STARVE_MAX=4 -> exe_ready=0 for 4 cycles, then exe_ready=1 and mem_ready=0 for one cycle; pattern repeats.
- Load formatting, mem_rdata=0x80FF_7F81:
  - LB addr 0 -> 0xFFFFFF81; LBU addr 0 -> 0x00000081.
  - LB addr 1 -> 0x0000007F.
  - LH addr 2 -> 0xFFFF80FF; LHU addr 2 -> 0x000080FF.
  - LW -> 0x80FF7F81.
- Scoreboard and x0:
  - Issue rd=7 -> rs1_busy=1 for rs1_idx=7 from the next cycle until the cycle after wb_rd_en with idx=7.
  - Re-issue rd=7 in the clear cycle -> stays busy.
  - Issue rd=0 -> never busy.
  - exe write to idx 0 -> wb_rd_en stays 0.
